prob_percent_unit: RTL and testbench
====================================

# prob_percent_unit

Multi-channel, handshaked successor to the single-channel probability-to-percent converter. Accepts a vector of N_CH class probabilities in Q(FRAC) format, converts them one channel per cycle through a single shared ×100 datapath, and applies round-half-up or truncation selectable per transaction. Outputs saturated 0–100 percentages, per-channel saturation flags and the arg-max channel. Sits between the MLP softmax/output stage and the display/UART formatting logic.

## Interface
- W, 8, probability word width (unsigned)
- FRAC, 6, fractional bits; 1.0 = 2^FRAC; FRAC ≥ 1 required
- N_CH, 2, number of channels (≥ 1)
- CW (localparam), max(1, $clog2(N_CH)), channel index width

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input vector valid
- in_ready  out  1  block can accept a vector (high only in IDLE)
- p_flat  in  N_CH*W  channel k at bits [k*W +: W], unsigned Q(FRAC)
- round_en  in  1  1 = round half up, 0 = truncate; sampled with p_flat
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  downstream accepts result
- pct_flat  out  N_CH*7  channel k percent at bits [k*7 +: 7], 0..100
- sat_flag  out  N_CH  bit k set if channel k was clamped to 100
- max_idx  out  CW  channel with largest percent
- max_pct  out  7  percent of max_idx

## Operation
- Reset values: in_ready=1, out_valid=0, pct_flat=0, sat_flag=0, max_idx=0, max_pct=0; FSM = IDLE, channel counter = 0.
- FSM states: IDLE, CONV, HOLD.
  - IDLE: in_ready=1. On in_valid & in_ready: latch p_flat and round_en into internal registers, clear sat_flag, max_idx, max_pct, set counter=0, go CONV.
  - CONV: in_ready=0. Each cycle processes channel `cnt`: prod = p*100 (W+7 bits, no overflow); sum = prod + (round_en_l ? 2^(FRAC-1) : 0); q = sum >> FRAC. If q > 100: pct=100 and sat_flag[cnt]=1, else pct=q[6:0]. Write pct into slot cnt of pct_flat. Arg-max update: if cnt==0 or pct > max_pct (strict), max_pct=pct and max_idx=cnt. Ties keep the lowest index. When cnt==N_CH-1, go HOLD and set out_valid=1; otherwise cnt++.
  - HOLD: out_valid=1. pct_flat, sat_flag, max_idx and max_pct stay stable. On out_ready: out_valid=0, go IDLE.
- Input changes on p_flat and round_en after acceptance have no effect on the transaction in flight.
- Result registers keep the last result after the handshake until the next transaction overwrites them slot by slot. Consumers sample them only while out_valid is high.
- Asserting rst_n low in any state aborts immediately and restores all reset values. There is no partial output.

## Timing
- Accept edge T0 (in_valid & in_ready). CONV occupies edges T1..T_N_CH. out_valid rises after edge T_N_CH, so latency is N_CH cycles from the accept edge.
- out_valid & out_ready at edge Th: out_valid low and in_ready high after Th. The next vector can be accepted at edge Th+1.
- Throughput with out_ready tied high: one vector per N_CH+2 cycles.
- in_ready is a pure decode of state==IDLE and has no combinational path from inputs.
- out_valid is registered and never drops without a handshake, except on reset.

## Test plan
- Basic conversion (N_CH=2, round_en=1): p0=64, p1=32 -> pct=100, 50; sat_flag=00; max_idx=0; max_pct=100; out_valid 2 cycles after the accept edge.
- Rounding vs truncation: p0=1, p1=31 with round_en=1 -> 2, 48. Same values with round_en=0 -> 1, 48. Also p0=33 with round_en=1 -> 52.
- Saturation: p0=255, p1=65 with round_en=1 -> 398 and 102 before clamping, both clamped to 100; sat_flag=11; max_idx=0 (tie rule).
- Tie and arg-max: p0=20, p1=20 -> max_idx=0; p0=10, p1=50 -> max_idx=1, max_pct=78.
- Back-pressure: hold out_ready low for 5 cycles in HOLD, and drive new in_valid and p_flat during that time. Outputs stay unchanged, in_ready=0, and nothing is accepted. Raise out_ready: IDLE one cycle later, then the pending vector is accepted.
- Reset mid-CONV: assert rst_n low after edge T1. All outputs go to their reset values asynchronously, in_ready=1 after release, and the next transaction produces correct results.

Source files
------------

// File: rtl/prob_percent_unit.sv
// Multi-channel probability-to-percent converter: one channel per cycle through a
// shared x100 / rounding / clamp datapath, with saturation flags and arg-max.
module prob_percent_unit #(
    parameter int W    = 8,
    parameter int FRAC = 6,
    parameter int N_CH = 2,
    localparam int CW  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_CH*W-1:0] p_flat,
    input  logic              round_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_CH*7-1:0] pct_flat,
    output logic [N_CH-1:0]   sat_flag,
    output logic [CW-1:0]     max_idx,
    output logic [6:0]        max_pct
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam int QW = W + 8;

    // One extra bit over p*100 so the rounding offset can never wrap.
    function automatic logic [QW-1:0] scale_q(input logic [W-1:0] p, input logic rnd);
        logic [QW-1:0] prod;
        logic [QW-1:0] sum;
        prod = QW'(p) * QW'(100);
        sum  = prod + (rnd ? (QW'(1) << (FRAC - 1)) : '0);
        return sum >> FRAC;
    endfunction

    function automatic logic [6:0] sat_pct(input logic [QW-1:0] q);
        return (q > QW'(100)) ? 7'd100 : q[6:0];
    endfunction

    logic [1:0]          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [N_CH*W-1:0]   p_l_q, p_l_d;
    logic                rnd_l_q, rnd_l_d;
    logic [N_CH*7-1:0]   pct_q, pct_d;
    logic [N_CH-1:0]     sat_q, sat_d;
    logic [CW-1:0]       max_idx_q, max_idx_d;
    logic [6:0]          max_pct_q, max_pct_d;
    logic                out_valid_q, out_valid_d;

    logic [W-1:0]        p_cur;
    logic [QW-1:0]       q_cur;
    logic [6:0]          pct_cur;
    logic                is_sat;

    always_comb begin
        p_cur = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (cnt_q == CW'(k)) p_cur = p_l_q[k*W +: W];
        end
        q_cur   = scale_q(p_cur, rnd_l_q);
        pct_cur = sat_pct(q_cur);
        is_sat  = (q_cur > QW'(100));
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        p_l_d       = p_l_q;
        rnd_l_d     = rnd_l_q;
        pct_d       = pct_q;
        sat_d       = sat_q;
        max_idx_d   = max_idx_q;
        max_pct_d   = max_pct_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    p_l_d     = p_flat;
                    rnd_l_d   = round_en;
                    sat_d     = '0;
                    max_idx_d = '0;
                    max_pct_d = '0;
                    cnt_d     = '0;
                    state_d   = S_CONV;
                end
            end
            S_CONV: begin
                for (int k = 0; k < N_CH; k++) begin
                    if (cnt_q == CW'(k)) begin
                        pct_d[k*7 +: 7] = pct_cur;
                        sat_d[k]        = is_sat;
                    end
                end
                // Strict compare keeps the lowest index on ties.
                if (cnt_q == '0 || pct_cur > max_pct_q) begin
                    max_pct_d = pct_cur;
                    max_idx_d = cnt_q;
                end
                if (cnt_q == CW'(N_CH - 1)) begin
                    state_d     = S_HOLD;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            p_l_q       <= '0;
            rnd_l_q     <= 1'b0;
            pct_q       <= '0;
            sat_q       <= '0;
            max_idx_q   <= '0;
            max_pct_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            p_l_q       <= p_l_d;
            rnd_l_q     <= rnd_l_d;
            pct_q       <= pct_d;
            sat_q       <= sat_d;
            max_idx_q   <= max_idx_d;
            max_pct_q   <= max_pct_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign pct_flat  = pct_q;
    assign sat_flag  = sat_q;
    assign max_idx   = max_idx_q;
    assign max_pct   = max_pct_q;

endmodule

// File: tb/tb_prob_percent_unit.sv
// Scoreboard bench for prob_percent_unit with the default 2-channel, Q6 configuration.
module tb_prob_percent_unit;

    localparam int W    = 8;
    localparam int FRAC = 6;
    localparam int N_CH = 2;
    localparam int CW   = 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [N_CH*W-1:0] p_flat;
    logic              round_en;
    logic              out_valid;
    logic              out_ready;
    logic [N_CH*7-1:0] pct_flat;
    logic [N_CH-1:0]   sat_flag;
    logic [CW-1:0]     max_idx;
    logic [6:0]        max_pct;

    prob_percent_unit #(.W(W), .FRAC(FRAC), .N_CH(N_CH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .p_flat(p_flat), .round_en(round_en), .out_valid(out_valid),
        .out_ready(out_ready), .pct_flat(pct_flat), .sat_flag(sat_flag),
        .max_idx(max_idx), .max_pct(max_pct)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] pct0;
        logic [6:0] pct1;
        logic [1:0] sat;
        logic       idx;
        logic [6:0] mx;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;
    int   n_acc    = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (in_valid && in_ready) begin
            acc_cyc <= cyc + 1;
            n_acc   <= n_acc + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [7:0] p0, input logic [7:0] p1,
                                  input bit r, output exp_t e);
        int v[2];
        int q;
        logic [6:0] pc[2];
        v[0] = p0;
        v[1] = p1;
        e.sat = 2'b00;
        for (int k = 0; k < 2; k++) begin
            q = (v[k] * 100 + (r ? 2 ** (FRAC - 1) : 0)) / (2 ** FRAC);
            if (q > 100) begin
                pc[k]    = 7'd100;
                e.sat[k] = 1'b1;
            end else begin
                pc[k] = 7'(q);
            end
        end
        e.pct0 = pc[0];
        e.pct1 = pc[1];
        e.idx  = (pc[1] > pc[0]);
        e.mx   = e.idx ? pc[1] : pc[0];
    endfunction

    task automatic send_vec(input logic [7:0] p0, input logic [7:0] p1, input bit r);
        exp_t e;
        int   n = 0;
        model(p0, p1, r, e);
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b1;
        p_flat   = {p1, p0};
        round_en = r;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("accept_wait", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        p_flat   = 16'($urandom);
        round_en = ~r;
    endtask

    task automatic compare_now(input string tag, input exp_t e);
        check_eq({tag, "_pct0"}, pct_flat[6:0], e.pct0);
        check_eq({tag, "_pct1"}, pct_flat[13:7], e.pct1);
        check_eq({tag, "_sat"}, sat_flag, e.sat);
        check_eq({tag, "_max_idx"}, max_idx, e.idx);
        check_eq({tag, "_max_pct"}, max_pct, e.mx);
    endtask

    task automatic wait_result(input string tag, output exp_t e);
        int n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_out_valid_wait"}, out_valid, 1);
        check_eq({tag, "_latency"}, cyc - acc_cyc, N_CH);
        check_eq({tag, "_in_ready_busy"}, in_ready, 0);
        e = sb.pop_front();
        compare_now(tag, e);
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({tag, "_out_valid_drop"}, out_valid, 0);
        check_eq({tag, "_in_ready_back"}, in_ready, 1);
    endtask

    task automatic run_vec(input string tag, input logic [7:0] p0, input logic [7:0] p1,
                           input bit r);
        exp_t e;
        send_vec(p0, p1, r);
        wait_result(tag, e);
        handshake(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t a;
        exp_t b;
        int   acc_before;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        p_flat    = '0;
        round_en  = 1'b0;
        #12;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_pct_flat", pct_flat, 0);
        check_eq("rst_sat_flag", sat_flag, 0);
        check_eq("rst_max_idx", max_idx, 0);
        check_eq("rst_max_pct", max_pct, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_vec("basic", 8'd64, 8'd32, 1'b1);
        run_vec("round", 8'd1, 8'd31, 1'b1);
        run_vec("trunc", 8'd1, 8'd31, 1'b0);
        run_vec("round33", 8'd33, 8'd0, 1'b1);
        run_vec("sat", 8'd255, 8'd65, 1'b1);
        run_vec("tie", 8'd20, 8'd20, 1'b1);
        run_vec("argmax", 8'd10, 8'd50, 1'b1);

        // Back-pressure: result must hold while a new vector waits.
        send_vec(8'd40, 8'd90, 1'b1);
        wait_result("bp_a", a);
        @(negedge clk);
        in_valid = 1'b1;
        p_flat   = {8'd50, 8'd10};
        round_en = 1'b1;
        model(8'd10, 8'd50, 1'b1, b);
        sb.push_back(b);
        acc_before = n_acc;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_hold_valid", out_valid, 1);
            check_eq("bp_hold_in_ready", in_ready, 0);
            compare_now("bp_hold", a);
        end
        check_eq("bp_no_accept", n_acc, acc_before);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check_eq("bp_idle_in_ready", in_ready, 1);
        check_eq("bp_idle_out_valid", out_valid, 0);
        check_eq("bp_idle_no_accept", n_acc, acc_before);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq("bp_pending_accepted", n_acc, acc_before + 1);
        wait_result("bp_b", b);
        handshake("bp_b");

        // Reset after the first conversion edge aborts the transaction.
        send_vec(8'd64, 8'd32, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        check_eq("mid_rst_out_valid", out_valid, 0);
        check_eq("mid_rst_pct_flat", pct_flat, 0);
        check_eq("mid_rst_sat_flag", sat_flag, 0);
        check_eq("mid_rst_max_idx", max_idx, 0);
        check_eq("mid_rst_max_pct", max_pct, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_in_ready", in_ready, 1);
        run_vec("post_rst", 8'd33, 8'd200, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
